vproc_mul_seq_block: RTL and testbench

Iterative signed 33x33-bit multiplier for the vector pipeline's multiply/multiply-high path, the multiplicative counterpart to the division block. It accepts sign- or zero-extended 33-bit operands, so one datapath serves MUL, MULH, MULHU and MULHSU. It uses a valid/ready handshake on both sides and returns the low or high 32-bit word of the 64-bit product. It is sized for area-constrained configurations where a single-cycle multiplier is too large.

---
 rtl/vproc_mul_seq_block.sv | 115 +++++++++++
 tb/tb_vproc_mul_seq_block.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vproc_mul_seq_block.sv
// ============================================================================
//  Module   : vproc_mul_seq_block
//  Purpose  : Iterative signed 33x33 multiplier, returns low or high product word
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vproc_mul_seq_block #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [32:0] op1_i,
    input  logic [32:0] op2_i,
    input  logic        high_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] res_o
);

    localparam int c_N     = 33 / BITS_PER_CYCLE;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [32:0]          r_mcand;
    logic [32:0]          r_mplier;
    logic                 r_sign;
    logic                 r_high;
    logic [65:0]          r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_valid;
    logic [31:0]          r_res;

    logic [32:0]          w_abs1;
    logic [32:0]          w_abs2;
    logic [65:0]          w_part;
    logic [6:0]           w_shamt;
    logic [65:0]          w_acc_next;
    logic [63:0]          w_prod;
    logic                 w_last;

    // |-2^32| wraps to 33'h1_0000_0000, which is the correct unsigned magnitude
    assign w_abs1 = op1_i[32] ? (~op1_i + 33'd1) : op1_i;
    assign w_abs2 = op2_i[32] ? (~op2_i + 33'd1) : op2_i;

    assign w_part     = 66'(r_mplier[BITS_PER_CYCLE-1:0]) * 66'(r_mcand);
    assign w_shamt    = 7'(r_cnt) * 7'(BITS_PER_CYCLE);
    assign w_acc_next = r_acc + (w_part << w_shamt);
    // Low 64 bits of the 66-bit negation equal the negation of the low 64 bits
    assign w_prod     = r_sign ? (~w_acc_next[63:0] + 64'd1) : w_acc_next[63:0];
    assign w_last     = (r_cnt == c_CNT_W'(c_N - 1));

    assign ready_o = (r_state == S_IDLE);
    assign valid_o = r_valid;
    assign res_o   = r_res;

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_high   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_res    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_mcand  <= w_abs1;
                        r_mplier <= w_abs2;
                        r_sign   <= op1_i[32] ^ op2_i[32];
                        r_high   <= high_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res   <= r_high ? w_prod[63:32] : w_prod[31:0];
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vproc_mul_seq_block.sv
// ============================================================================
//  Module   : tb_vproc_mul_seq_block
//  Purpose  : Self-checking bench driving three multiplier widths in lockstep
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vproc_mul_seq_block;

    localparam int c_NS [3] = '{33, 11, 3};

    logic        clk = 1'b0;
    logic        async_rst_i;
    logic        valid_i;
    logic        ready_i;
    logic [32:0] op1;
    logic [32:0] op2;
    logic        high;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [31:0] res [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vproc_mul_seq_block #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk_i(clk), .async_rst_i(async_rst_i), .valid_i(valid_i), .ready_o(rdy[0]),
        .op1_i(op1), .op2_i(op2), .high_i(high), .valid_o(vld[0]), .ready_i(ready_i),
        .res_o(res[0]));
    vproc_mul_seq_block #(.BITS_PER_CYCLE(3)) u_dut3 (
        .clk_i(clk), .async_rst_i(async_rst_i), .valid_i(valid_i), .ready_o(rdy[1]),
        .op1_i(op1), .op2_i(op2), .high_i(high), .valid_o(vld[1]), .ready_i(ready_i),
        .res_o(res[1]));
    vproc_mul_seq_block #(.BITS_PER_CYCLE(11)) u_dut11 (
        .clk_i(clk), .async_rst_i(async_rst_i), .valid_i(valid_i), .ready_o(rdy[2]),
        .op1_i(op1), .op2_i(op2), .high_i(high), .valid_o(vld[2]), .ready_i(ready_i),
        .res_o(res[2]));

    function automatic logic [31:0] model(input logic [32:0] a, input logic [32:0] b,
                                          input logic h);
        logic signed [65:0] p;
        p = $signed({{33{a[32]}}, a}) * $signed({{33{b[32]}}, b});
        return h ? p[63:32] : p[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [32:0] a, input logic [32:0] b, input logic h,
                       input string tag);
        logic [31:0] exp;
        logic [31:0] got [3];
        int          lat [3];
        exp = model(a, b, h);
        for (int k = 0; k < 3; k++) begin
            got[k] = '0;
            lat[k] = -1;
        end
        @(negedge clk);
        check($sformatf("%s_ready", tag), 64'(rdy), 64'(3'b111));
        op1 = a; op2 = b; high = h; valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op1 = 33'($urandom()); op2 = 33'($urandom()); high = ~h;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (vld[k] && lat[k] < 0) begin
                    lat[k] = e;
                    got[k] = res[k];
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_res%0d", tag, k), 64'(got[k]), 64'(exp));
            check($sformatf("%s_lat%0d", tag, k), 64'(lat[k]), 64'(c_NS[k]));
        end
    endtask

    task automatic rand_op(output logic [32:0] v, input bit sgn);
        logic [31:0] r;
        r = $urandom();
        v = {sgn ? r[31] : 1'b0, r};
    endtask

    initial begin
        logic [32:0] a;
        logic [32:0] b;
        logic [31:0] hold [3];
        async_rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        op1 = '0; op2 = '0; high = 1'b0;
        #1;
        check("rst_ready", 64'(rdy), 64'(3'b111));
        check("rst_valid", 64'(vld), 64'(3'b000));
        check("rst_res", {res[0], res[1] | res[2]}, 64'd0);
        @(negedge clk);
        async_rst_i = 1'b0;

        run(33'h0_0000_0007, 33'h0_0000_0006, 1'b0, "signed_low");
        run(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b1, "mulhu_hi");
        run(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, "mulhu_lo");
        run(33'h1_FFFF_FFFE, 33'h0_0000_0003, 1'b1, "mulhsu_hi");
        run(33'h1_FFFF_FFFE, 33'h0_0000_0003, 1'b0, "mulhsu_lo");
        run(33'h1_0000_0000, 33'h1_0000_0000, 1'b0, "corner_lo");
        run(33'h1_0000_0000, 33'h1_0000_0000, 1'b1, "corner_hi");
        run(33'h1_FFFF_FFFF, 33'h1_8000_0000, 1'b1, "neg1_hi");
        run(33'h0_0000_0000, 33'h1_2345_6789, 1'b0, "zero_op");

        for (int i = 0; i < 16; i++) begin
            rand_op(a, bit'($urandom_range(0, 1)));
            rand_op(b, bit'($urandom_range(0, 1)));
            run(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        // Output backpressure: results must hold while new requests are ignored
        @(negedge clk);
        op1 = 33'h1_FFFF_FFF9; op2 = 33'h0_0000_0101; high = 1'b0;
        valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("bp_valid", 64'(vld), 64'(3'b111));
        check("bp_ready", 64'(rdy), 64'(3'b000));
        for (int k = 0; k < 3; k++) begin
            hold[k] = res[k];
            check($sformatf("bp_res%0d", k), 64'(res[k]),
                  64'(model(33'h1_FFFF_FFF9, 33'h0_0000_0101, 1'b0)));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid_i = ~valid_i; op1 = 33'($urandom()); op2 = 33'($urandom()); high = ~high;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_v%0d", c), 64'(vld), 64'(3'b111));
            check($sformatf("bp_hold_r%0d", c), 64'(rdy), 64'(3'b000));
            check($sformatf("bp_hold_d%0d", c), {res[0], res[1] ^ res[2]},
                  {hold[0], hold[1] ^ hold[2]});
        end
        @(negedge clk);
        valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(vld), 64'(3'b000));
        check("bp_release_ready", 64'(rdy), 64'(3'b111));

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        op1 = 33'h0_0000_0007; op2 = 33'h0_0000_0006; high = 1'b0;
        valid_i = 1'b1; ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        async_rst_i = 1'b1;
        #1;
        check("mid_rst_valid", 64'(vld), 64'(3'b000));
        check("mid_rst_ready", 64'(rdy), 64'(3'b111));
        check("mid_rst_res", {res[0] | res[1], res[2]}, 64'd0);
        @(negedge clk);
        async_rst_i = 1'b0;
        run(33'h0_0000_0003, 33'h0_0000_0005, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
